pref_issue_queue: RTL



---
 rtl/pref_pkg.sv | 20 ++
 rtl/pref_issue_queue_if.sv | 35 +++
 rtl/pref_cand_compact.sv | 48 ++++
 rtl/pref_issue_queue.sv | 97 +++++++++
 4 files changed

// File: rtl/pref_pkg.sv
// Shared prefetcher types: address/line-address widths and conversion helpers.
// Used by the IP-stride prefetcher and the prefetch issue queue.
package pref_pkg;

  localparam int unsigned ADDR_SIZE       = 64;
  localparam int unsigned LOG2_BLOCK_SIZE = 6;
  localparam int unsigned CLA_SIZE        = ADDR_SIZE - LOG2_BLOCK_SIZE;

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [CLA_SIZE-1:0]  cla_t;

  function automatic cla_t addr_to_cla(input addr_t addr);
    return addr[ADDR_SIZE-1:LOG2_BLOCK_SIZE];
  endfunction

  function automatic addr_t cla_to_addr(input cla_t cla);
    return {cla, {LOG2_BLOCK_SIZE{1'b0}}};
  endfunction

endpackage

// File: rtl/pref_issue_queue_if.sv
// Candidate/issue bundle of the prefetch issue queue.
// master = prefetcher/requester side, slave = the queue itself.
interface pref_issue_queue_if
  import pref_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 8
);
  addr_t                        pref_addr1_i;
  addr_t                        pref_addr2_i;
  addr_t                        pref_addr3_i;
  logic                         pref_valid1_i;
  logic                         pref_valid2_i;
  logic                         pref_valid3_i;
  logic                         flush_i;
  addr_t                        issue_addr_o;
  logic                         issue_valid_o;
  logic                         issue_ready_i;
  logic [$clog2(QUEUE_DEPTH):0] occupancy_o;
  logic [15:0]                  drop_count_o;

  modport master (
    output pref_addr1_i, pref_addr2_i, pref_addr3_i,
    output pref_valid1_i, pref_valid2_i, pref_valid3_i,
    output flush_i, issue_ready_i,
    input  issue_addr_o, issue_valid_o, occupancy_o, drop_count_o
  );

  modport slave (
    input  pref_addr1_i, pref_addr2_i, pref_addr3_i,
    input  pref_valid1_i, pref_valid2_i, pref_valid3_i,
    input  flush_i, issue_ready_i,
    output issue_addr_o, issue_valid_o, occupancy_o, drop_count_o
  );

endinterface

// File: rtl/pref_cand_compact.sv
// Compacts up to three candidates into consecutive slots, limited by free slots.
// PREF_DEDUP_EN: duplicates (vs queue or earlier same-cycle candidate) are silently removed.
module pref_cand_compact
  import pref_pkg::*;
#(
  parameter int unsigned FREE_W = 4
) (
  input  logic [2:0]        i_valid,
  input  cla_t [2:0]        i_cla,
  input  logic [FREE_W-1:0] i_free,
`ifdef PREF_DEDUP_EN
  input  logic [2:0]        i_match,
`endif
  output cla_t [2:0]        o_cla,
  output logic [1:0]        o_accept_cnt,
  output logic [1:0]        o_drop_cnt
);

  logic [2:0] w_elig;

  always_comb begin
    w_elig = i_valid;
`ifdef PREF_DEDUP_EN
    w_elig[0] = i_valid[0] & ~i_match[0];
    w_elig[1] = i_valid[1] & ~i_match[1] & ~(w_elig[0] & (i_cla[1] == i_cla[0]));
    w_elig[2] = i_valid[2] & ~i_match[2] & ~(w_elig[0] & (i_cla[2] == i_cla[0]))
                & ~(w_elig[1] & (i_cla[2] == i_cla[1]));
`endif
  end

  // Earliest eligible candidates win the free slots; the rest count as full drops.
  always_comb begin
    o_cla        = '0;
    o_accept_cnt = '0;
    o_drop_cnt   = '0;
    for (int k = 0; k < 3; k++) begin
      if (w_elig[k]) begin
        if (FREE_W'(o_accept_cnt) < i_free) begin
          o_cla[o_accept_cnt] = i_cla[k];
          o_accept_cnt        = o_accept_cnt + 2'd1;
        end else begin
          o_drop_cnt = o_drop_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pref_issue_queue.sv
// Circular FIFO of prefetch line addresses, 3-wide enqueue, 1-wide valid/ready issue.
// Optional PREF_DEDUP_EN drops candidates already present in the queue.
module pref_issue_queue
  import pref_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  pref_issue_queue_if.slave io_q
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  cla_t             r_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [OCC_W-1:0] r_occ;
  logic [15:0]      r_drop;

  logic             w_deq;
  logic [OCC_W-1:0] w_free;
  logic [2:0]       w_valid;
  cla_t [2:0]       w_cla;
  cla_t [2:0]       w_comp;
  logic [1:0]       w_accept;
  logic [1:0]       w_dropn;
  logic [16:0]      w_drop_sum;

  assign w_deq   = (r_occ != '0) & io_q.issue_ready_i;
  // A same-cycle dequeue frees its slot for same-cycle enqueue.
  assign w_free  = OCC_W'(QUEUE_DEPTH) - r_occ + OCC_W'(w_deq);
  assign w_valid = {io_q.pref_valid3_i, io_q.pref_valid2_i, io_q.pref_valid1_i};
  assign w_cla   = {addr_to_cla(io_q.pref_addr3_i), addr_to_cla(io_q.pref_addr2_i),
                    addr_to_cla(io_q.pref_addr1_i)};

`ifdef PREF_DEDUP_EN
  logic [2:0] w_match;

  // The head entry still counts as present even if it is dequeued this cycle.
  always_comb begin
    w_match = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        if ((OCC_W'(PTR_W'(PTR_W'(i) - r_head)) < r_occ) && (r_mem[i] == w_cla[k])) begin
          w_match[k] = 1'b1;
        end
      end
    end
  end
`endif

  pref_cand_compact #(
    .FREE_W (OCC_W)
  ) u_compact (
    .i_valid      (w_valid),
    .i_cla        (w_cla),
    .i_free       (w_free),
`ifdef PREF_DEDUP_EN
    .i_match      (w_match),
`endif
    .o_cla        (w_comp),
    .o_accept_cnt (w_accept),
    .o_drop_cnt   (w_dropn)
  );

  assign w_drop_sum = {1'b0, r_drop} + 17'(w_dropn);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_drop <= '0;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) r_mem[i] <= '0;
    end else if (io_q.flush_i) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (j < int'(w_accept)) r_mem[r_tail + PTR_W'(j)] <= w_comp[j];
      end
      r_tail <= r_tail + PTR_W'(w_accept);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      r_occ  <= r_occ + OCC_W'(w_accept) - OCC_W'(w_deq);
      r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign io_q.issue_valid_o = (r_occ != '0);
  assign io_q.issue_addr_o  = cla_to_addr(r_mem[r_head]);
  assign io_q.occupancy_o   = r_occ;
  assign io_q.drop_count_o  = r_drop;

endmodule
